data_mem_ctrl: RTL and testbench
================================

Name: data_mem_ctrl

Overview:
Parametrised, byte-addressable data memory with a valid/ready request port and a registered response port. It serves the MEM stage of the pipeline and replaces the fixed-size, combinational-read data memory. It adds per-byte write strobes, 1-cycle registered reads, and alignment/range error reporting. After reset, a sequencer clears the array one word per cycle instead of resetting it in bulk.

Parameters:
WORD_LEN, 32, data word width in bits; must be a multiple of CELL_SIZE.
CELL_SIZE, 8, bits per addressable cell (byte).
ADDR_W, 16, byte-address width.
DEPTH_WORDS, 256, number of words in the array; must be a power of two and no larger than 2^ADDR_W / BYTES.
Derived: BYTES = WORD_LEN/CELL_SIZE; OFS_W = log2(BYTES); IDX_W = log2(DEPTH_WORDS).

Ports:
clk  in  1  clock; all state changes on the rising edge.
rst  in  1  asynchronous reset, active-low.
req_valid  in  1  request present.
req_ready  out  1  request accepted when req_valid && req_ready.
req_we  in  1  1 = write, 0 = read.
req_be  in  BYTES  byte write strobes; ignored for reads.
req_addr  in  ADDR_W  byte address.
req_wdata  in  WORD_LEN  write data.
rsp_valid  out  1  one-cycle pulse, one per accepted request.
rsp_rdata  out  WORD_LEN  read data; 0 for writes and errors.
rsp_err  out  1  misaligned or out-of-range access.
init_done  out  1  clear sweep finished.

Behaviour:
- Reset values while rst=0: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, init_done=0, state=INIT, sweep index=0.
- FSM states are INIT and RUN. There is no read-wait state, because the response register carries the pipeline.
- INIT: on each cycle, write 0 to word[sweep index] and increment the index. When the index reaches DEPTH_WORDS-1, that word is cleared and the FSM moves to RUN on the same edge. Total sweep is DEPTH_WORDS cycles after rst rises.
- In INIT, req_ready=0; requests are not accepted and produce no response.
- RUN: req_ready=1 constantly, with no response backpressure. One request can be accepted per cycle, and back-to-back requests are supported.
- Address decode: word index = req_addr[OFS_W+IDX_W-1:OFS_W].
  - err = (req_addr[OFS_W-1:0] != 0) || (req_addr >> OFS_W) >= DEPTH_WORDS.
- Byte order is big-endian. Lane i of a word (bits [CELL_SIZE*i+CELL_SIZE-1 : CELL_SIZE*i]) maps to byte address base + (BYTES-1-i). The lowest address holds the MSB.
- Write accepted at edge N:
  - Lanes with req_be[i]=1 update at edge N; other lanes keep their value.
  - At edge N, rsp_valid=1, rsp_err=err, rsp_rdata=0.
  - If err=1, the array is not modified.
- Read accepted at edge N:
  - At edge N, rsp_valid=1, rsp_rdata=word[index] (or 0 if err), rsp_err=err. The response is visible in cycle N+1, so latency is 1 cycle.
- Read-after-write to the same word on consecutive accepted cycles returns the newly written data.
- req_be=0 write: acknowledged with no array change.
- rsp_valid deasserts the cycle after any cycle with no accepted request.
- Reset asserted mid-operation: outputs go to their reset values immediately (asynchronously). Any in-flight response is lost, and the clear sweep restarts from index 0 after rst rises.
- Array contents during the sweep are undefined until init_done=1.

Decomposition:
- Shared defines: WORD_LEN, MEM_CELL_SIZE, DATA_MEM_SIZE defaults.
- Shared defines: FSM state encodings MEM_INIT and MEM_RUN.
- One sub-module: mem_bank_be, a synchronous single-port array with per-lane write enables and a registered read. data_mem_ctrl holds the FSM, decode, error logic and response register.

Test Plan:
- Release rst, DEPTH_WORDS=256 -> init_done and req_ready rise after exactly 256 cycles; a read of 0x0000 returns 0x00000000 with err=0.
- Write 0x11223344 to 0x0010 with be=1111, then read 0x0010 the next cycle -> rdata=0x11223344, rsp_valid 1 cycle after each accept.
- Write 0xAABBCCDD to 0x0010 with be=0101, then read -> rdata=0x11BB33DD; byte address 0x0010 holds 0x11.
- Read 0x0012 (misaligned) and read 0x0400 (out of range at 256 words) -> rsp_err=1, rdata=0. A write to 0x0012 leaves word 4 unchanged.
- Streaming: 4 back-to-back reads of 0x0,0x4,0x8,0xC after writes 1,2,3,4 -> rsp_valid high for 4 consecutive cycles with rdata 1,2,3,4.
- Assert rst during the streaming read sequence and during INIT sweep index 100 -> rsp_valid drops immediately; the sweep restarts and init_done returns 256 cycles after release.

Source files
------------

// File: rtl/data_mem_ctrl_pkg.sv
// Shared defaults and FSM state encoding for the MEM-stage data memory controller.
package data_mem_ctrl_pkg;

    localparam int MEM_WORD_LEN  = 32;
    localparam int MEM_CELL_SIZE = 8;
    localparam int MEM_ADDR_W    = 16;
    localparam int DATA_MEM_SIZE = 256;

    typedef enum logic {
        MEM_INIT = 1'b0,
        MEM_RUN  = 1'b1
    } mem_state_e;

endpackage

// File: rtl/data_mem_ctrl_mem_bank_be.sv
// Single-port word array with per-lane write enables and a registered read port.
module mem_bank_be #(
    parameter int WORD_LEN    = 32,
    parameter int CELL_SIZE   = 8,
    parameter int DEPTH_WORDS = 256
) (
    input  logic                          clk,
    input  logic [WORD_LEN/CELL_SIZE-1:0] we,
    input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
    input  logic [WORD_LEN-1:0]           wdata,
    input  logic                          re,
    output logic [WORD_LEN-1:0]           rdata
);

    localparam int BYTES = WORD_LEN / CELL_SIZE;

    logic [WORD_LEN-1:0] mem [DEPTH_WORDS];

    // NOTE: the array has no reset; the controller's clear sweep zeroes it word by word.
    always_ff @(posedge clk) begin
        for (int i = 0; i < BYTES; i++) begin
            if (we[i]) begin
                mem[addr][i*CELL_SIZE +: CELL_SIZE] <= wdata[i*CELL_SIZE +: CELL_SIZE];
            end
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// Byte-addressable big-endian data memory: clear sweep after reset, then one
// valid/ready request per cycle with a registered 1-cycle response.
module data_mem_ctrl
    import data_mem_ctrl_pkg::*;
#(
    parameter int WORD_LEN    = MEM_WORD_LEN,
    parameter int CELL_SIZE   = MEM_CELL_SIZE,
    parameter int ADDR_W      = MEM_ADDR_W,
    parameter int DEPTH_WORDS = DATA_MEM_SIZE
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic                          req_we,
    input  logic [WORD_LEN/CELL_SIZE-1:0] req_be,
    input  logic [ADDR_W-1:0]             req_addr,
    input  logic [WORD_LEN-1:0]           req_wdata,
    output logic                          rsp_valid,
    output logic [WORD_LEN-1:0]           rsp_rdata,
    output logic                          rsp_err,
    output logic                          init_done
);

    localparam int BYTES = WORD_LEN / CELL_SIZE;
    localparam int OFS_W = $clog2(BYTES);
    localparam int IDX_W = $clog2(DEPTH_WORDS);

    mem_state_e         state, next_state;
    logic [IDX_W-1:0]   sweep_idx, next_idx;
    logic               accept, addr_err, rd_en, rsp_rd;
    logic [IDX_W-1:0]   bank_addr;
    logic [BYTES-1:0]   bank_we;
    logic [WORD_LEN-1:0] bank_wdata, bank_rdata;

    assign req_ready = (state == MEM_RUN);
    assign init_done = (state == MEM_RUN);
    assign accept    = req_valid && req_ready;
    assign addr_err  = (req_addr[OFS_W-1:0] != '0) ||
                       ((req_addr >> OFS_W) >= ADDR_W'(DEPTH_WORDS));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= MEM_INIT;
            sweep_idx <= '0;
        end else begin
            state     <= next_state;
            sweep_idx <= next_idx;
        end
    end

    // NOTE: every output of this block gets a default first so no latch can be inferred.
    always_comb begin
        next_state = state;
        next_idx   = sweep_idx;
        bank_addr  = req_addr[OFS_W+IDX_W-1:OFS_W];
        bank_we    = '0;
        bank_wdata = req_wdata;
        rd_en      = 1'b0;
        case (state)
            MEM_INIT: begin
                bank_addr  = sweep_idx;
                bank_we    = '1;
                bank_wdata = '0;
                next_idx   = sweep_idx + 1'b1;
                if (sweep_idx == IDX_W'(DEPTH_WORDS - 1)) begin
                    next_state = MEM_RUN;
                end
            end
            MEM_RUN: begin
                if (accept && !addr_err) begin
                    if (req_we) bank_we = req_be;
                    else        rd_en   = 1'b1;
                end
            end
            default: next_state = MEM_INIT;
        endcase
    end

    mem_bank_be #(
        .WORD_LEN    (WORD_LEN),
        .CELL_SIZE   (CELL_SIZE),
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_bank (
        .clk   (clk),
        .we    (bank_we),
        .addr  (bank_addr),
        .wdata (bank_wdata),
        .re    (rd_en),
        .rdata (bank_rdata)
    );

    // The bank register holds the read word; rsp_rd gates it so writes/errors return 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rd    <= 1'b0;
        end else begin
            rsp_valid <= accept;
            rsp_err   <= accept && addr_err;
            rsp_rd    <= rd_en;
        end
    end

    assign rsp_rdata = rsp_rd ? bank_rdata : '0;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl against a byte-array big-endian model.
module tb_data_mem_ctrl;

    localparam int DEPTH  = 256;
    localparam int NBYTES = DEPTH * 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [3:0]  req_be = '0;
    logic [15:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        init_done;

    int checks   = 0;
    int failures = 0;

    logic [7:0] mem_model [NBYTES];

    always #5 clk = ~clk;

    data_mem_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_be    (req_be),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .init_done (init_done)
    );

    function automatic logic model_err(input logic [15:0] a);
        return (a % 4 != 0) || (int'(a) / 4 >= DEPTH);
    endfunction

    // Lowest byte address holds the most significant lane.
    function automatic logic [31:0] model_read(input logic [15:0] a);
        logic [31:0] w;
        for (int i = 0; i < 4; i++) w[8*i +: 8] = mem_model[int'(a) + 3 - i];
        return w;
    endfunction

    task automatic model_write(input logic [15:0] a, input logic [3:0] be, input logic [31:0] d);
        for (int i = 0; i < 4; i++)
            if (be[i]) mem_model[int'(a) + 3 - i] = d[8*i +: 8];
    endtask

    task automatic model_clear();
        for (int i = 0; i < NBYTES; i++) mem_model[i] = 8'h00;
    endtask

    task automatic do_req(input logic we, input logic [3:0] be, input logic [15:0] addr,
                          input logic [31:0] wdata, input string name);
        logic        e;
        logic [31:0] exp;
        e   = model_err(addr);
        exp = (we || e) ? 32'h0 : model_read(addr);
        if (we && !e) model_write(addr, be, wdata);
        checks++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s_ready: req_ready=%b, expected 1", name, req_ready);
        end
        req_valid = 1'b1; req_we = we; req_be = be; req_addr = addr; req_wdata = wdata;
        @(posedge clk); #1;
        req_valid = 1'b0;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_err !== e || rsp_rdata !== exp) begin
            failures++;
            $display("FAIL %s: valid=%b err=%b rdata=%h, expected valid=1 err=%b rdata=%h",
                     name, rsp_valid, rsp_err, rsp_rdata, e, exp);
        end
    endtask

    task automatic idle(input int n, input string name);
        req_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        checks++;
        if (rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL %s_idle: rsp_valid=%b, expected 0", name, rsp_valid);
        end
    endtask

    // Caller has just released rst at a negedge; holds a read request to prove none is accepted.
    task automatic wait_init(input string name);
        int   cnt;
        logic bad;
        cnt = 0; bad = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h0000;
        while (init_done !== 1'b1 && cnt < 1000) begin
            @(posedge clk); #1;
            cnt++;
            if (rsp_valid !== 1'b0 || (init_done !== 1'b1 && req_ready !== 1'b0)) bad = 1'b1;
        end
        req_valid = 1'b0;
        checks++;
        if (cnt != DEPTH) begin
            failures++;
            $display("FAIL %s_sweep_len: init_done after %0d cycles, expected %0d", name, cnt, DEPTH);
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL %s_init_quiet: response or ready seen during sweep, expected none", name);
        end
        model_clear();
    endtask

    task automatic check_reset_outputs(input string name);
        checks++;
        if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 ||
            rsp_err !== 1'b0 || init_done !== 1'b0) begin
            failures++;
            $display("FAIL %s: ready=%b valid=%b rdata=%h err=%b done=%b, expected all 0",
                     name, req_ready, rsp_valid, rsp_rdata, rsp_err, init_done);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset_state");
        @(negedge clk) rst = 1'b1;
        wait_init("first");
        do_req(1'b0, 4'h0, 16'h0000, 32'h0, "read_zero_after_init");
    endtask

    task automatic test_basic_rw();
        do_req(1'b1, 4'hF, 16'h0010, 32'h11223344, "write_full");
        do_req(1'b0, 4'h0, 16'h0010, 32'h0, "raw_full");
        idle(1, "basic");
    endtask

    task automatic test_byte_strobe();
        do_req(1'b1, 4'b0101, 16'h0010, 32'hAABBCCDD, "write_be0101");
        do_req(1'b0, 4'h0, 16'h0010, 32'h0, "read_be0101");
        checks++;
        if (mem_model[16'h0010] !== 8'h11 || model_read(16'h0010) !== 32'h11BB33DD) begin
            failures++;
            $display("FAIL model_be0101: byte10=%h word=%h, expected 11 and 11bb33dd",
                     mem_model[16'h0010], model_read(16'h0010));
        end
        do_req(1'b1, 4'b0000, 16'h0010, 32'hFFFFFFFF, "write_be0000");
        do_req(1'b0, 4'h0, 16'h0010, 32'h0, "read_after_be0000");
        idle(2, "strobe");
    endtask

    task automatic test_errors();
        do_req(1'b0, 4'h0, 16'h0012, 32'h0, "read_misaligned");
        do_req(1'b0, 4'h0, 16'h0400, 32'h0, "read_out_of_range");
        do_req(1'b1, 4'hF, 16'h0012, 32'hDEADBEEF, "write_misaligned");
        do_req(1'b1, 4'hF, 16'hFFFC, 32'hCAFEF00D, "write_out_of_range");
        do_req(1'b0, 4'h0, 16'h0010, 32'h0, "word4_unchanged");
        do_req(1'b0, 4'h0, 16'h03FC, 32'h0, "last_word");
        idle(1, "errors");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) do_req(1'b1, 4'hF, 16'(i * 4), 32'(i + 1), "stream_write");
        for (int i = 0; i < 4; i++) do_req(1'b0, 4'h0, 16'(i * 4), 32'h0, "stream_read");
        idle(1, "stream");
    endtask

    task automatic test_random();
        logic [15:0] a;
        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 9))
                0:       a = 16'($urandom_range(0, 31) * 4 + $urandom_range(1, 3));
                1:       a = 16'($urandom_range(DEPTH, 16383) * 4);
                2:       a = 16'($urandom_range(0, DEPTH - 1) * 4);
                default: a = 16'($urandom_range(0, 15) * 4);
            endcase
            do_req(1'($urandom_range(0, 1)), 4'($urandom), a, $urandom, "random");
            if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3), "random");
        end
    endtask

    task automatic test_reset_midop();
        for (int i = 0; i < 4; i++) do_req(1'b1, 4'hF, 16'(i * 4), 32'(i + 10), "pre_reset_write");
        do_req(1'b0, 4'h0, 16'h0000, 32'h0, "pre_reset_read0");
        req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h0004;
        #2 rst = 1'b0;
        #1;
        check_reset_outputs("async_reset_stream");
        req_valid = 1'b0;
        @(negedge clk) rst = 1'b1;
        wait_init("after_stream_reset");
        do_req(1'b0, 4'h0, 16'h0004, 32'h0, "cleared_after_reset");

        rst = 1'b0;
        #1;
        check_reset_outputs("reset_before_sweep");
        @(negedge clk) rst = 1'b1;
        repeat (100) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check_reset_outputs("async_reset_sweep100");
        @(negedge clk) rst = 1'b1;
        wait_init("after_sweep_reset");
        do_req(1'b0, 4'h0, 16'h03FC, 32'h0, "read_last_after_restart");
    endtask

    initial begin
        model_clear();
        test_reset();
        test_basic_rw();
        test_byte_strobe();
        test_errors();
        test_back_to_back();
        test_random();
        test_reset_midop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
